conv1d_stream: RTL and testbench

- Parametrised streaming 1-D linear convolution engine. It is the successor of the fixed 8-bit convol block.
- Loads an N-tap kernel, streams an M-sample input, and emits all M+N-1 full-precision outputs, including the tail flush.
- Valid/ready handshakes on every stream; optional signed arithmetic. Sits between the sample source and the result sink in the MLA datapath.

---
 rtl/conv_pkg.sv | 27 ++
 rtl/conv_mac.sv | 33 +++
 rtl/conv1d_stream.sv | 141 ++++++++++++++
 tb/tb_conv1d_stream.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared state encodings and width helpers for the streaming 1-D convolution engine.
package conv_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_K = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] FLUSH  = 3'd3;
    localparam logic [2:0] FIN    = 3'd4;

    function automatic int clog2(input int v);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Full-precision width of an n-tap sum of dw x dw products; n=1 gives 2*dw.
    function automatic int calc_ow(input int dw, input int n);
        return 2 * dw + clog2(n);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Combinational N-tap multiply-accumulate; operands are sign- or zero-extended to OW.
module conv_mac
    import conv_pkg::*;
#(
    parameter int DW     = 8,
    parameter int N      = 5,
    parameter int SIGNED = 0,
    parameter int OW     = calc_ow(DW, N)
) (
    input  logic [N*DW-1:0] kern,
    input  logic [N*DW-1:0] win,
    output logic [OW-1:0]   sum
);

    function automatic logic signed [OW-1:0] ext(input logic [DW-1:0] v);
        logic fill;
        fill = (SIGNED != 0) && v[DW-1];
        return $signed({{(OW-DW){fill}}, v});
    endfunction

    logic signed [OW-1:0] acc;

    // OW is wide enough for the whole sum, so arithmetic modulo 2^OW is exact.
    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++) begin
            acc = acc + ext(kern[i*DW +: DW]) * ext(win[i*DW +: DW]);
        end
    end

    assign sum = acc;

endmodule

// File: rtl/conv1d_stream.sv
// Streaming 1-D linear convolution: loads N kernel taps, streams M samples, emits M+N-1 outputs.
module conv1d_stream
    import conv_pkg::*;
#(
    parameter int DW     = 8,
    parameter int M      = 6,
    parameter int N      = 5,
    parameter int SIGNED = 0,
    parameter int OW     = calc_ow(DW, N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          k_valid,
    input  logic [DW-1:0] k_data,
    output logic          k_ready,
    input  logic          x_valid,
    input  logic [DW-1:0] x_data,
    output logic          x_ready,
    output logic          y_valid,
    output logic [OW-1:0] y_data,
    output logic          y_last,
    input  logic          y_ready,
    output logic          busy,
    output logic          done
);

    localparam int          HW    = (N > 1) ? (N - 1) * DW : DW;
    localparam logic [31:0] KLAST = 32'(N - 1);
    localparam logic [31:0] XLAST = 32'(M - 1);
    localparam logic [31:0] FLAST = 32'((N > 1) ? N - 2 : 0);

    logic [2:0]      state;
    logic [31:0]     kcnt;
    logic [31:0]     xcnt;
    logic [31:0]     fcnt;
    logic [N*DW-1:0] kvec;
    logic [HW-1:0]   hist;
    logic [N*DW-1:0] win;
    logic [DW-1:0]   smp;
    logic [OW-1:0]   mac;
    logic            adv;
    logic            fire;
    logic            last_out;

    // A new result may be loaded whenever the output register is empty or draining.
    assign adv     = !y_valid || y_ready;
    assign k_ready = (state == LOAD_K);
    assign x_ready = (state == STREAM) && adv;
    assign busy    = (state != IDLE);
    assign smp     = (state == STREAM) ? x_data : '0;
    assign fire    = ((state == STREAM) && x_valid && adv) || ((state == FLUSH) && adv);

    assign last_out = ((state == FLUSH) && (fcnt == FLAST)) ||
                      ((state == STREAM) && (N == 1) && (xcnt == XLAST));

    always_comb begin
        win = '0;
        win[DW-1:0] = smp;
        for (int i = 1; i < N; i++) begin
            win[i*DW +: DW] = hist[(i-1)*DW +: DW];
        end
    end

    conv_mac #(
        .DW     (DW),
        .N      (N),
        .SIGNED (SIGNED),
        .OW     (OW)
    ) u_mac (
        .kern (kvec),
        .win  (win),
        .sum  (mac)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            kcnt    <= '0;
            xcnt    <= '0;
            fcnt    <= '0;
            kvec    <= '0;
            hist    <= '0;
            y_data  <= '0;
            y_valid <= 1'b0;
            y_last  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD_K;
                        kcnt  <= '0;
                        xcnt  <= '0;
                        fcnt  <= '0;
                        hist  <= '0;
                    end
                end
                LOAD_K: begin
                    if (k_valid) begin
                        kvec[kcnt*DW +: DW] <= k_data;
                        kcnt <= kcnt + 32'd1;
                        if (kcnt == KLAST) state <= STREAM;
                    end
                end
                STREAM: begin
                    if (fire) begin
                        xcnt <= xcnt + 32'd1;
                        if (xcnt == XLAST) state <= (N == 1) ? FIN : FLUSH;
                    end
                end
                FLUSH: begin
                    if (fire) begin
                        fcnt <= fcnt + 32'd1;
                        if (fcnt == FLAST) state <= FIN;
                    end
                end
                FIN: begin
                    if (y_valid && y_ready) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Output register stage: load a new MAC result or drain on handshake.
            if (fire) begin
                hist    <= win[HW-1:0];
                y_data  <= mac;
                y_valid <= 1'b1;
                y_last  <= last_out;
            end else if (y_valid && y_ready) begin
                y_valid <= 1'b0;
                y_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv1d_stream.sv
// Scoreboard bench for conv1d_stream: base, backpressure, max, abort, signed and N=1 configurations.
module tb_conv1d_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       k_valid, x_valid, y_ready;
    logic [7:0] k_data, x_data;
    logic       start_b, start_s, start_n;

    logic        kr_b, xr_b, yv_b, yl_b, bz_b, dn_b;
    logic [18:0] yd_b;
    logic        kr_s, xr_s, yv_s, yl_s, bz_s, dn_s;
    logic [18:0] yd_s;
    logic        kr_n, xr_n, yv_n, yl_n, bz_n, dn_n;
    logic [15:0] yd_n;

    always #5 clk = ~clk;

    conv1d_stream #(.DW(8), .M(6), .N(5), .SIGNED(0)) u_base (
        .clk(clk), .rst(rst), .start(start_b),
        .k_valid(k_valid), .k_data(k_data), .k_ready(kr_b),
        .x_valid(x_valid), .x_data(x_data), .x_ready(xr_b),
        .y_valid(yv_b), .y_data(yd_b), .y_last(yl_b), .y_ready(y_ready),
        .busy(bz_b), .done(dn_b));

    conv1d_stream #(.DW(8), .M(6), .N(5), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .start(start_s),
        .k_valid(k_valid), .k_data(k_data), .k_ready(kr_s),
        .x_valid(x_valid), .x_data(x_data), .x_ready(xr_s),
        .y_valid(yv_s), .y_data(yd_s), .y_last(yl_s), .y_ready(y_ready),
        .busy(bz_s), .done(dn_s));

    conv1d_stream #(.DW(8), .M(3), .N(1), .SIGNED(0)) u_n1 (
        .clk(clk), .rst(rst), .start(start_n),
        .k_valid(k_valid), .k_data(k_data), .k_ready(kr_n),
        .x_valid(x_valid), .x_data(x_data), .x_ready(xr_n),
        .y_valid(yv_n), .y_data(yd_n), .y_last(yl_n), .y_ready(y_ready),
        .busy(bz_n), .done(dn_n));

    int   sel;
    logic k_rdy, x_rdy, y_vld, y_lst, bz, dn;
    int   y_val;

    always_comb begin
        case (sel)
            1: begin
                k_rdy = kr_s; x_rdy = xr_s; y_vld = yv_s; y_lst = yl_s; bz = bz_s; dn = dn_s;
                y_val = {{13{yd_s[18]}}, yd_s};
            end
            2: begin
                k_rdy = kr_n; x_rdy = xr_n; y_vld = yv_n; y_lst = yl_n; bz = bz_n; dn = dn_n;
                y_val = {16'd0, yd_n};
            end
            default: begin
                k_rdy = kr_b; x_rdy = xr_b; y_vld = yv_b; y_lst = yl_b; bz = bz_b; dn = dn_b;
                y_val = {13'd0, yd_b};
            end
        endcase
    end

    typedef struct {
        int v;
        bit last;
    } exp_t;

    exp_t sb[$];
    int   ylog[$];
    int   kk[8];
    int   xx[8];
    int   nn, mm;
    bit   sgn;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic int sv8(input int v);
        return (sgn && v >= 128) ? v - 256 : v;
    endfunction

    function automatic int model(input int t);
        int s;
        s = 0;
        for (int j = 0; j < nn; j++) begin
            if (t - j >= 0 && t - j < mm) s += sv8(kk[j]) * sv8(xx[t-j]);
        end
        return s;
    endfunction

    task automatic set_start(input int s, input bit v);
        start_b = (s == 0) && v;
        start_s = (s == 1) && v;
        start_n = (s == 2) && v;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_yv"}, y_vld, 0);
        chk({tag, "_yd"}, y_val, 0);
        chk({tag, "_yl"}, y_lst, 0);
        chk({tag, "_busy"}, bz, 0);
        chk({tag, "_done"}, dn, 0);
        chk({tag, "_krdy"}, k_rdy, 0);
        chk({tag, "_xrdy"}, x_rdy, 0);
    endtask

    // Runs one job on instance s; bp selects the 1,0,0,1 y_ready pattern,
    // stray is a cycle at which start is re-pulsed, abort_after>0 stops after that many outputs.
    task automatic run_job(input int s, input bit bp, input int stray, input int abort_after);
        int   ki, xi, nout, cyc, first_cyc, last_cyc, ndone, tot, prev_y;
        bit   prev_stall;
        exp_t e;
        ki = 0; xi = 0; nout = 0; cyc = 0; first_cyc = -1; last_cyc = -1; ndone = 0;
        prev_stall = 0; prev_y = 0;
        tot = mm + nn - 1;
        sel = s;
        sb.delete();
        ylog.delete();
        @(negedge clk);
        while (cyc < 300) begin
            set_start(s, (cyc == 0) || (cyc == stray));
            y_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            k_valid = (ki < nn);
            k_data  = (ki < nn) ? 8'(kk[ki]) : 8'd0;
            x_valid = (xi < mm);
            x_data  = (xi < mm) ? 8'(xx[xi]) : 8'd0;
            #1;
            if (y_vld && !y_ready) chk("xrdy_stall", x_rdy, 0);
            if (prev_stall) begin
                chk("hold_v", y_vld, 1);
                chk("hold_d", y_val, prev_y);
            end
            prev_stall = y_vld && !y_ready;
            prev_y = y_val;
            if (dn) begin
                ndone++;
                chk("done_cyc", cyc, last_cyc + 1);
            end
            if (y_vld && y_ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                ylog.push_back(y_val);
                if (sb.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("y", y_val, e.v);
                    chk("ylast", y_lst, e.last);
                end
                nout++;
                if (y_lst) last_cyc = cyc;
            end
            if (k_valid && k_rdy) ki++;
            if (x_valid && x_rdy) begin
                sb.push_back('{model(xi), (xi == tot - 1)});
                xi++;
                if (xi == mm) begin
                    for (int t = mm; t < tot; t++) sb.push_back('{model(t), (t == tot - 1)});
                end
            end
            if (abort_after > 0 && nout == abort_after) break;
            if (last_cyc >= 0 && cyc == last_cyc + 2) break;
            cyc++;
            @(negedge clk);
        end
        set_start(s, 1'b0);
        k_valid = 1'b0;
        x_valid = 1'b0;
        if (abort_after == 0) begin
            chk("finished", (last_cyc >= 0), 1);
            chk("ndone", ndone, 1);
            chk("nout", nout, tot);
            chk("sb_left", sb.size(), 0);
            if (!bp) chk("thru", last_cyc - first_cyc, tot - 1);
        end
    endtask

    task automatic load_base();
        int kb[5] = '{3, 2, 3, 2, 3};
        int xb[6] = '{1, 4, 3, 4, 3, 1};
        nn = 5; mm = 6; sgn = 0;
        for (int i = 0; i < 5; i++) kk[i] = kb[i];
        for (int i = 0; i < 6; i++) xx[i] = xb[i];
    endtask

    initial begin
        rst = 1'b0;
        k_valid = 1'b0; x_valid = 1'b0; y_ready = 1'b0;
        k_data = 8'd0; x_data = 8'd0;
        sel = 0;
        set_start(0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check_idle("rst");
        @(negedge clk);
        rst = 1'b1;

        load_base();
        run_job(0, 1'b0, 9, 0);
        run_job(0, 1'b1, 0, 0);

        nn = 5; mm = 6; sgn = 0;
        for (int i = 0; i < 8; i++) begin kk[i] = 255; xx[i] = 255; end
        run_job(0, 1'b0, 0, 0);
        if (ylog.size() > 4) chk("peak", ylog[4], 325125);
        else chk("peak_missing", ylog.size(), 5);

        load_base();
        run_job(0, 1'b0, 0, 3);
        rst = 1'b0;
        #1;
        check_idle("abort");
        @(negedge clk);
        rst = 1'b1;
        run_job(0, 1'b0, 0, 0);

        nn = 5; mm = 6; sgn = 1;
        for (int i = 0; i < 8; i++) begin kk[i] = 255; xx[i] = 127; end
        run_job(1, 1'b0, 0, 0);
        if (ylog.size() > 5) begin
            chk("sgn_y0", ylog[0], -127);
            chk("sgn_y5", ylog[5], -635);
        end else chk("sgn_missing", ylog.size(), 10);

        nn = 1; mm = 3; sgn = 0;
        kk[0] = 2; xx[0] = 1; xx[1] = 4; xx[2] = 3;
        run_job(2, 1'b0, 0, 0);
        run_job(2, 1'b1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
